// File: rtl/bar_pkg.sv
// ---------------------------------------------------------------------------
// bar_pkg -- shared definitions for the "bar" word-transfer channel.
//   BAR_DATA_W : width of one transferred word (32 bits)
//   bar_data_t : the word type carried on the channel and stored in buffers
// ---------------------------------------------------------------------------
package bar_pkg;

  localparam int BAR_DATA_W = 32;

  typedef logic [BAR_DATA_W-1:0] bar_data_t;

endpackage : bar_pkg

// File: rtl/bar_if.sv
// ---------------------------------------------------------------------------
// bar -- valid/ready word channel.
//   data  : word being offered by the sender
//   valid : sender has a word on data
//   ready : receiver can take a word this cycle
// Modports: tx (sending end), rx (receiving end).
// ---------------------------------------------------------------------------
interface bar;
  import bar_pkg::*;

  bar_data_t data;
  logic      valid;
  logic      ready;

  modport tx (output data, output valid, input  ready);
  modport rx (input  data, input  valid, output ready);

endinterface : bar

// File: rtl/bar_fifo.sv
// ---------------------------------------------------------------------------
// bar_fifo -- circular word buffer with occupancy tracking.
// Parameters:
//   DEPTH        : number of words stored; power of two, 2..16
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset (clears pointers and level)
//   i_push       : write i_data at the write pointer this edge
//   i_pop        : retire the word at the read pointer this edge
//   i_data       : word to write
//   o_head       : word at the read pointer (meaningless while empty)
//   o_level      : current occupancy
//   o_level_next : occupancy after this edge (used for a registered ready)
// The caller guarantees no push when full and no pop when empty.
// ---------------------------------------------------------------------------
module bar_fifo
  import bar_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  bar_data_t               i_data,
  output bar_data_t               o_head,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic [$clog2(DEPTH):0]  o_level_next
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  bar_data_t             r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [LVL_W-1:0]      r_level;
  logic [LVL_W-1:0]      w_level_next;

  always_comb begin
    w_level_next = r_level;
    if (i_push && !i_pop) begin
      w_level_next = r_level + 1'b1;
    end else if (i_pop && !i_push) begin
      w_level_next = r_level - 1'b1;
    end
  end

  // Storage needs no reset: the read side is masked while empty.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      end
      if (i_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      end
      r_level <= w_level_next;
    end
  end

  assign o_head       = r_mem[r_rd_ptr];
  assign o_level      = r_level;
  assign o_level_next = w_level_next;

endmodule : bar_fifo

// File: rtl/bar_receiver.sv
// ---------------------------------------------------------------------------
// bar_receiver -- receiving end of a bar channel feeding a small FIFO.
// Parameters:
//   DEPTH     : number of buffered words; power of two, 2..16
// Ports:
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   x         : bar channel, receiving end (reads data/valid, drives ready)
//   out_data  : oldest buffered word (0 while empty)
//   out_valid : buffer non-empty
//   out_ready : downstream takes out_data this cycle
//   level     : current occupancy
//   rx_count  : count of accepted words, wraps at 2^32
//               (only present when BAR_RECEIVER_COUNT_EN is defined)
// Build option: define BAR_RECEIVER_COUNT_EN to add rx_count.
// ---------------------------------------------------------------------------
module bar_receiver
  import bar_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  bar.rx                          x,
  output bar_data_t               out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [$clog2(DEPTH):0]  level
`ifdef BAR_RECEIVER_COUNT_EN
  ,
  output logic [31:0]             rx_count
`endif
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             r_ready;
  logic             w_push;
  logic             w_pop;
  bar_data_t        w_head;
  logic [LVL_W-1:0] w_level;
  logic [LVL_W-1:0] w_level_next;

  // Nothing moves on a reset edge, even if the handshakes are asserted.
  assign w_push = x.valid && r_ready && !rst;
  assign w_pop  = out_valid && out_ready && !rst;

  bar_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_pop        (w_pop),
    .i_data       (x.data),
    .o_head       (w_head),
    .o_level      (w_level),
    .o_level_next (w_level_next)
  );

  // ready is a flop loaded from next-cycle occupancy, so it equals
  // (level < DEPTH) without any combinational path from valid/out_ready.
  // Being low through reset, it also rises one cycle after reset drops.
  // A pop while full only frees space for the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= (w_level_next < LVL_W'(DEPTH));
    end
  end

  assign x.ready   = r_ready;
  assign out_valid = (w_level != '0);
  assign out_data  = out_valid ? w_head : '0;
  assign level     = w_level;

`ifdef BAR_RECEIVER_COUNT_EN
  logic [31:0] r_rx_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_count <= '0;
    end else if (w_push) begin
      r_rx_count <= r_rx_count + 32'd1;
    end
  end

  assign rx_count = r_rx_count;
`endif

endmodule : bar_receiver

// File: tb/tb_bar_receiver.sv
// ---------------------------------------------------------------------------
// tb_bar_receiver -- directed bench for bar_receiver (DEPTH = 4).
// Accepted words are queued as expected output; a monitor forked from the
// main sequence pops and compares whenever the DUT delivers a word.
// ---------------------------------------------------------------------------
module tb_bar_receiver;
  import bar_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       out_ready = 1'b0;
  bar_data_t  out_data;
  logic       out_valid;
  logic [2:0] level;
`ifdef BAR_RECEIVER_COUNT_EN
  logic [31:0] rx_count;
`endif

  bar x_if ();

  bar_receiver #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .x         (x_if),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .level     (level)
`ifdef BAR_RECEIVER_COUNT_EN
    ,
    .rx_count  (rx_count)
`endif
  );

  always #5 clk = ~clk;

  int        n_vec = 0;
  int        n_bad = 0;
  bar_data_t exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h), required %0d (0x%08h)", name, act, act, req, req);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Inputs change 1 ns after the rising edge; the monitor samples on the
  // falling edge, i.e. the values that the next rising edge will act on.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL pop_unexpected: got %0d, required no output", out_data);
          end else begin
            chk("pop_data", out_data, exp_q.pop_front());
          end
        end
        if (x_if.valid && x_if.ready) begin
          exp_q.push_back(x_if.data);
        end
      end
    end
  endtask

  initial begin
    x_if.valid = 1'b0;
    x_if.data  = '0;
    fork
      monitor();
    join_none

    // Reset state
    step();
    step();
    chk("rst_level", 32'(level), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(x_if.ready), 0);
    chk("rst_out_data", out_data, 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(x_if.ready), 1);

    // Single word
    x_if.data = 42; x_if.valid = 1'b1;
    step();
    x_if.valid = 1'b0; x_if.data = 32'hDEAD_BEEF;
    chk("single_out_valid", 32'(out_valid), 1);
    chk("single_out_data", out_data, 42);
    chk("single_level", 32'(level), 1);
`ifdef BAR_RECEIVER_COUNT_EN
    chk("single_rx_count", rx_count, 1);
`endif
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("single_drained", 32'(level), 0);

    // Fill: four accepted, fifth held until a pop frees space
    for (int i = 1; i <= 4; i++) begin
      x_if.data = i; x_if.valid = 1'b1;
      step();
    end
    chk("fill_level", 32'(level), 4);
    chk("fill_ready", 32'(x_if.ready), 0);
    x_if.data = 5;
    step();
    step();
    chk("full_hold_level", 32'(level), 4);
    chk("full_hold_ready", 32'(x_if.ready), 0);
    chk("full_hold_data", out_data, 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("pop_from_full_level", 32'(level), 3);
    chk("ready_after_pop", 32'(x_if.ready), 1);
    step();
    x_if.valid = 1'b0;
    chk("fifth_accepted_level", 32'(level), 4);
    chk("fifth_head_data", out_data, 2);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    out_ready = 1'b0;
    chk("fill_drained", 32'(level), 0);

    // Streaming 0..99 with simultaneous push and pop
    out_ready = 1'b1; x_if.valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      x_if.data = i;
      step();
      chk("stream_level", 32'(level), 1);
    end
    x_if.valid = 1'b0;
    step();
    out_ready = 1'b0;
    chk("stream_drained", 32'(level), 0);

    // Pointer wrap: 10 rounds of 3 words
    for (int r = 0; r < 10; r++) begin
      x_if.valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
        x_if.data = 200 + r * 3 + k;
        step();
      end
      x_if.valid = 1'b0;
      chk("wrap_level3", 32'(level), 3);
      out_ready = 1'b1;
      for (int k = 0; k < 3; k++) step();
      out_ready = 1'b0;
      chk("wrap_level0", 32'(level), 0);
    end
`ifdef BAR_RECEIVER_COUNT_EN
    chk("count_total", rx_count, 136);
`endif

    // Reset mid-stream with three words buffered
    x_if.valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      x_if.data = 300 + k;
      step();
    end
    x_if.valid = 1'b0;
    chk("pre_rst_level", 32'(level), 3);
    rst = 1'b1; x_if.valid = 1'b1; x_if.data = 999; out_ready = 1'b1;
    step();
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_ready", 32'(x_if.ready), 0);
    chk("mid_rst_out_data", out_data, 0);
`ifdef BAR_RECEIVER_COUNT_EN
    chk("mid_rst_rx_count", rx_count, 0);
`endif
    rst = 1'b0; x_if.valid = 1'b0; out_ready = 1'b0;
    step();
    chk("mid_rst_ready_rise", 32'(x_if.ready), 1);
    chk("mid_rst_still_empty", 32'(level), 0);
    x_if.data = 400; x_if.valid = 1'b1;
    step();
    x_if.valid = 1'b0;
    chk("post_rst_data", out_data, 400);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_rst_drained", 32'(level), 0);

`ifdef BAR_RECEIVER_COUNT_EN
    // Counter wrap
    force dut.r_rx_count = 32'hFFFF_FFFF;
    step();
    release dut.r_rx_count;
    x_if.data = 500; x_if.valid = 1'b1;
    step();
    x_if.valid = 1'b0;
    chk("count_wrap", rx_count, 0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
`endif

    step();
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule : tb_bar_receiver
